// File: rtl/dma_bd_load_scheduler.sv
// Picks the next internal buffer descriptor to load into the DMA engine.
// Two priority classes, round-robin inside each, with a bound on high-priority bursts.
module dma_bd_load_scheduler #(
   parameter int unsigned NUM_INT_BDS       = 4,
   parameter int unsigned NUM_INT_BDS_WIDTH = 2,
   parameter int unsigned HP_BURST_MAX      = 4,
   parameter int unsigned CNT_WIDTH         = 3
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic [NUM_INT_BDS-1:0]       strtDMAOp,
   input  logic [NUM_INT_BDS-1:0]       strtDMAOpInt,
   input  logic [NUM_INT_BDS-1:0]       hiPriMask,
   input  logic [NUM_INT_BDS-1:0]       abortBD,
   input  logic                         ldIntDscrptrAck,
   output logic                         ldDscrptr,
   output logic [NUM_INT_BDS_WIDTH-1:0] ldDscrptrNum,
   output logic [NUM_INT_BDS-1:0]       pendingBDs,
   output logic                         busy
);

   typedef enum logic [0:0] {StArb, StGrant} stateT;

   stateT                        state;
   logic [NUM_INT_BDS_WIDTH-1:0] hpPtr;
   logic [NUM_INT_BDS_WIDTH-1:0] lpPtr;
   logic [CNT_WIDTH-1:0]         hpCnt;
   logic                         grantHp;

   logic [NUM_INT_BDS-1:0]       hpReq;
   logic [NUM_INT_BDS-1:0]       lpReq;
   logic                         pickHp;
   logic [NUM_INT_BDS-1:0]       classReq;
   logic [NUM_INT_BDS_WIDTH-1:0] classPtr;
   logic [NUM_INT_BDS_WIDTH-1:0] selIdx;
   logic [NUM_INT_BDS_WIDTH-1:0] cand;
   logic                         found;
   logic [NUM_INT_BDS_WIDTH-1:0] nextPtr;
   logic [NUM_INT_BDS-1:0]       grantOh;
   logic [NUM_INT_BDS-1:0]       ackClr;
   logic [NUM_INT_BDS-1:0]       pendingNext;
   logic                         ackEdge;

   assign hpReq    = pendingBDs & hiPriMask;
   assign lpReq    = pendingBDs & ~hiPriMask;
   assign pickHp   = (|hpReq) && ((lpReq == '0) || (hpCnt < CNT_WIDTH'(HP_BURST_MAX)));
   assign classReq = pickHp ? hpReq : lpReq;
   assign classPtr = pickHp ? hpPtr : lpPtr;

   // First requester at or after the class pointer, wrapping past the top index.
   always_comb begin
      selIdx = '0;
      cand   = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < NUM_INT_BDS; i++) begin
         cand = NUM_INT_BDS_WIDTH'((32'(classPtr) + i) % NUM_INT_BDS);
         if (!found && classReq[cand]) begin
            found  = 1'b1;
            selIdx = cand;
         end
      end
   end

   assign nextPtr = NUM_INT_BDS_WIDTH'((32'(ldDscrptrNum) + 32'd1) % NUM_INT_BDS);
   assign ackEdge = (state == StGrant) && ldIntDscrptrAck;

   always_comb begin
      grantOh = '0;
      if (ldDscrptr) grantOh[ldDscrptrNum] = 1'b1;
   end

   assign ackClr = ackEdge ? grantOh : '0;
   // New starts win over clears; an abort never touches the presented grant.
   assign pendingNext = (pendingBDs & ~(ackClr | (abortBD & ~grantOh)))
                        | strtDMAOp | strtDMAOpInt;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= StArb;
         ldDscrptr    <= 1'b0;
         ldDscrptrNum <= '0;
         pendingBDs   <= '0;
         hpPtr        <= '0;
         lpPtr        <= '0;
         hpCnt        <= '0;
         grantHp      <= 1'b0;
      end else begin
         pendingBDs <= pendingNext;
         unique case (state)
            StArb: begin
               if (lpReq == '0) hpCnt <= '0;
               if (|pendingBDs) begin
                  ldDscrptr    <= 1'b1;
                  ldDscrptrNum <= selIdx;
                  grantHp      <= pickHp;
                  state        <= StGrant;
               end
            end
            StGrant: begin
               if (ldIntDscrptrAck) begin
                  ldDscrptr    <= 1'b0;
                  ldDscrptrNum <= '0;
                  state        <= StArb;
                  if (grantHp) begin
                     hpPtr <= nextPtr;
                     if (hpCnt < CNT_WIDTH'(HP_BURST_MAX)) hpCnt <= hpCnt + 1'b1;
                  end else begin
                     lpPtr <= nextPtr;
                     hpCnt <= '0;
                  end
               end
            end
            default: state <= StArb;
         endcase
      end
   end

   assign busy = ldDscrptr | (|pendingBDs);

endmodule

// File: tb/tb_dma_bd_load_scheduler.sv
// Bench for dma_bd_load_scheduler: cycle vectors for latency/re-arm/abort,
// plus a grant-order scoreboard for round-robin, burst bound and reset recovery.
module tb_dma_bd_load_scheduler;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] strtDMAOp = '0;
   logic [3:0] strtDMAOpInt = '0;
   logic [3:0] hiPriMask = '0;
   logic [3:0] abortBD = '0;
   logic       ldIntDscrptrAck = 1'b0;
   logic       ldDscrptr;
   logic [1:0] ldDscrptrNum;
   logic [3:0] pendingBDs;
   logic       busy;

   int nChecks = 0;
   int nFails  = 0;
   int expQ[$];

   typedef struct packed {
      logic [3:0] strt;
      logic [3:0] strtInt;
      logic [3:0] abort;
      logic       ack;
      logic       expLd;
      logic [1:0] expNum;
      logic [3:0] expPend;
      logic       expBusy;
   } vecT;

   vecT vecs[17];

   dma_bd_load_scheduler #(
      .NUM_INT_BDS       (4),
      .NUM_INT_BDS_WIDTH (2),
      .HP_BURST_MAX      (4),
      .CNT_WIDTH         (3)
   ) dut (
      .clock           (clock),
      .resetn          (resetn),
      .strtDMAOp       (strtDMAOp),
      .strtDMAOpInt    (strtDMAOpInt),
      .hiPriMask       (hiPriMask),
      .abortBD         (abortBD),
      .ldIntDscrptrAck (ldIntDscrptrAck),
      .ldDscrptr       (ldDscrptr),
      .ldDscrptrNum    (ldDscrptrNum),
      .pendingBDs      (pendingBDs),
      .busy            (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Acks each grant in its first cycle; optionally re-requests granted BDs in the ack cycle.
   task automatic runGrants(input int nGrants, input logic [3:0] reReqMask, input int reReqLimit);
      int   g = 0;
      logic prevLd = 1'b0;
      for (int cyc = 0; cyc < 200 && g < nGrants; cyc++) begin
         @(negedge clock);
         strtDMAOp       = '0;
         ldIntDscrptrAck = 1'b0;
         if (prevLd) chk("arb gap", ldDscrptr, 0);
         prevLd = ldDscrptr;
         if (ldDscrptr) begin
            if (expQ.size() == 0) begin
               chk("unexpected grant", ldDscrptrNum, 99);
            end else begin
               chk($sformatf("grant order #%0d", g), ldDscrptrNum, expQ.pop_front());
            end
            ldIntDscrptrAck = 1'b1;
            if (g < reReqLimit && reReqMask[ldDscrptrNum]) strtDMAOp[ldDscrptrNum] = 1'b1;
            g++;
         end
      end
      @(negedge clock);
      strtDMAOp       = '0;
      ldIntDscrptrAck = 1'b0;
      if (g < nGrants) chk("grant timeout", g, nGrants);
   endtask

   initial begin
      // strt, strtInt, abort, ack | expLd, expNum, expPend, expBusy
      vecs[0]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b1};
      vecs[1]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
      vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
      vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
      vecs[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
      vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
      vecs[6]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b1};
      vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
      vecs[8]  = '{4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1};
      vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1};
      vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
      vecs[11] = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b1};
      vecs[12] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0110, 1'b1};
      vecs[13] = '{4'b0000, 4'b0000, 4'b0110, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1};
      vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1};
      vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
      vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};

      // Reset state
      #12;
      chk("reset ldDscrptr", ldDscrptr, 0);
      chk("reset ldDscrptrNum", ldDscrptrNum, 0);
      chk("reset pendingBDs", pendingBDs, 0);
      chk("reset busy", busy, 0);
      @(negedge clock);
      resetn = 1'b1;

      // Round-robin, all low priority
      @(negedge clock);
      strtDMAOp = 4'b1111;
      expQ.push_back(0); expQ.push_back(1); expQ.push_back(2); expQ.push_back(3);
      runGrants(4, 4'b0000, 0);
      strtDMAOp = 4'b1001;
      expQ.push_back(0); expQ.push_back(3);
      runGrants(2, 4'b0000, 0);

      // Cycle vectors: single request latency, ack in ARB, re-arm, abort
      for (int r = 0; r < 17; r++) begin
         @(negedge clock);
         strtDMAOp       = vecs[r].strt;
         strtDMAOpInt    = vecs[r].strtInt;
         abortBD         = vecs[r].abort;
         ldIntDscrptrAck = vecs[r].ack;
         @(posedge clock);
         #1;
         chk($sformatf("vec%0d ldDscrptr", r), ldDscrptr, vecs[r].expLd);
         chk($sformatf("vec%0d ldDscrptrNum", r), ldDscrptrNum, vecs[r].expNum);
         chk($sformatf("vec%0d pendingBDs", r), pendingBDs, vecs[r].expPend);
         chk($sformatf("vec%0d busy", r), busy, vecs[r].expBusy);
      end
      @(negedge clock);
      strtDMAOp = '0; strtDMAOpInt = '0; abortBD = '0; ldIntDscrptrAck = 1'b0;

      // Starvation bound: BDs 0,1 high priority and re-requested, BD2 low priority
      hiPriMask = 4'b0011;
      strtDMAOp = 4'b0111;
      expQ.push_back(0); expQ.push_back(1); expQ.push_back(0); expQ.push_back(1);
      expQ.push_back(2); expQ.push_back(0); expQ.push_back(1); expQ.push_back(0);
      runGrants(8, 4'b0011, 6);
      hiPriMask = 4'b0000;
      chk("post-burst pendingBDs", pendingBDs, 0);

      // Reset while a grant is outstanding
      strtDMAOp = 4'b0100;
      begin
         int waited = 0;
         @(negedge clock);
         strtDMAOp = '0;
         while (!ldDscrptr && waited < 10) begin
            @(negedge clock);
            waited++;
         end
         chk("pre-reset grant num", ldDscrptrNum, 2);
      end
      #2 resetn = 1'b0;
      #1;
      chk("mid-reset ldDscrptr", ldDscrptr, 0);
      chk("mid-reset ldDscrptrNum", ldDscrptrNum, 0);
      chk("mid-reset pendingBDs", pendingBDs, 0);
      chk("mid-reset busy", busy, 0);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      strtDMAOp = 4'b1010;
      expQ.push_back(1);
      runGrants(1, 4'b0000, 0);
      expQ.push_back(3);
      runGrants(1, 4'b0000, 0);
      @(negedge clock);
      chk("final busy", busy, 0);
      chk("scoreboard drained", expQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
